demux3_buf: RTL
===============

Name: demux3_buf

Overview:
- Buffered 1-to-3 steering block; the inverse of the datapath 3:1 select muxes.
- Accepts one d_width word per cycle with a 2-bit destination select, and delivers it to one of three output channels.
- Each output channel has a single-entry register and a valid/ready handshake.
- Used to route ALU/immediate results to three downstream consumers (register write-back, PC load, I/O latch) without combinational select paths crossing stage boundaries.

Parameters:
- d_width, 12, data word width.
- sel_width, 2, destination select width (fixed at 2; codes 00/01/10 legal, 11 illegal).
- errcnt_width, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word on in_sel this cycle.
- in_data  input  d_width  input word.
- in_sel  input  sel_width  destination: 00→ch0, 01→ch1, 10→ch2, 11 illegal.
- out0_valid / out1_valid / out2_valid  output  1 each  channel holds a word.
- out0_ready / out1_ready / out2_ready  input  1 each  consumer takes the word.
- out0_data / out1_data / out2_data  output  d_width each  channel word (registered).
- err_sel  output  1  one-cycle pulse, the cycle after an illegal-select word is accepted.
- err_count  output  errcnt_width  number of illegal-select words accepted, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outN_valid = 0, outN_data = 0, err_sel = 0, err_count = 0.
  - Any buffered words are discarded; nothing is delivered after reset deasserts.
- Acceptance: a transfer occurs on a clk edge where in_valid && in_ready.
- in_ready is combinational from in_sel and the channel state only; it never depends on in_valid.
  - Legal sel=k: in_ready = !outk_valid || outk_ready (fall-through refill allowed).
  - sel=11: in_ready = 1 (always accepted, then dropped).
- Latency: a word accepted at edge N appears on outk_data with outk_valid = 1 after edge N (1 cycle). There is no combinational path from in_data to outk_data.
- Channel state, per channel, two states:
  - EMPTY → FULL on a write.
  - FULL → EMPTY on outk_ready with no simultaneous write.
  - FULL stays FULL on outk_ready plus a simultaneous write: data is replaced by the new word and valid does not drop.
  - FULL with !outk_ready: outk_data and outk_valid are held stable and in_ready for that channel is 0.
- Channels are independent: a stall on one channel never blocks acceptance for another sel value.
- At most one channel is written per cycle. Other channels may drain the same cycle.
- Illegal sel (11) accepted:
  - No channel is written.
  - err_sel = 1 for exactly the next cycle.
  - err_count increments by 1, saturating at 2^errcnt_width−1 (stays 255 with default width).
  - Back-to-back illegal words give err_sel high on consecutive cycles.
- in_valid low: no state change except draining.
- X on in_sel while in_valid = 0 must not affect any state.

Decomposition:
- Shared package: SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_ILL=2'b11; default D_WIDTH=12, shared with the mux blocks.
- Sub-module demux3_slot: single-entry register with valid/ready, write strobe and write data in. Instantiated three times.
- Top level holds the select decode, in_ready generation and the error counter.

Test Plan:
- Reset, then in_sel=01, in_data=12'hA5C, in_valid=1, all outN_ready=0 → next cycle out1_valid=1, out1_data=12'hA5C; out0/out2 valid stay 0; in_ready for sel=01 is now 0.
- Channel 1 full and stalled; send sel=00 data 12'h123, then sel=10 data 12'h456 → both accepted on consecutive cycles; out0=12'h123, out2=12'h456; out1 unchanged at 12'hA5C.
- Channel 2 full, out2_ready=1 and sel=10 data 12'h789 in the same cycle → accepted; out2_valid stays 1 and out2_data becomes 12'h789 next cycle.
- Three consecutive sel=11 words → in_ready=1 throughout; err_sel high for 3 cycles, one cycle delayed; err_count=3; no outN_valid rises.
- 300 illegal words → err_count saturates at 255 and stays there.
- Fill all three channels (12'h001/002/003), assert rst_n=0 mid-cycle with no clk edge → all valids, data, err_count 0 immediately; after release, no stale word appears.

Source files
------------

// File: rtl/demux3_buf_pkg.sv
// demux3_buf_pkg: select codes, default width and slot states shared with the datapath mux blocks
package demux3_buf_pkg;
    localparam int D_WIDTH = 12;
    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;
    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;
endpackage

// File: rtl/demux3_buf_slot.sv
// demux3_buf_slot: single-entry output register with valid/ready handshake
module demux3_buf_slot import demux3_buf_pkg::*; #(
    parameter int W = D_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d = SLOT_FULL;
            data_d  = wr_data;
        end else if (state_q == SLOT_FULL && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = state_q == SLOT_FULL;
    assign out_data  = data_q;
endmodule

// File: rtl/demux3_buf.sv
// demux3_buf: buffered 1-to-3 steering with per-channel registers and a saturating illegal-select counter
module demux3_buf import demux3_buf_pkg::*; #(
    parameter int d_width      = D_WIDTH,
    parameter int sel_width    = 2,
    parameter int errcnt_width = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [d_width-1:0]      in_data,
    input  logic [sel_width-1:0]    in_sel,
    output logic                    out0_valid,
    output logic                    out1_valid,
    output logic                    out2_valid,
    input  logic                    out0_ready,
    input  logic                    out1_ready,
    input  logic                    out2_ready,
    output logic [d_width-1:0]      out0_data,
    output logic [d_width-1:0]      out1_data,
    output logic [d_width-1:0]      out2_data,
    output logic                    err_sel,
    output logic [errcnt_width-1:0] err_count
);
    logic                    acc, wr0, wr1, wr2, ill;
    logic                    err_sel_q, err_sel_d;
    logic [errcnt_width-1:0] err_count_q, err_count_d;

    // Readiness looks only at the addressed channel so a stalled channel never blocks the others
    always_comb begin
        in_ready    = (in_sel == SEL_CH0) ? (!out0_valid || out0_ready) :
                      (in_sel == SEL_CH1) ? (!out1_valid || out1_ready) :
                      (in_sel == SEL_CH2) ? (!out2_valid || out2_ready) : 1'b1;
        acc         = in_valid && in_ready;
        wr0         = acc && in_sel == SEL_CH0;
        wr1         = acc && in_sel == SEL_CH1;
        wr2         = acc && in_sel == SEL_CH2;
        ill         = acc && in_sel == SEL_ILL;
        err_sel_d   = ill;
        err_count_d = (ill && err_count_q != {errcnt_width{1'b1}}) ? err_count_q + 1'b1 : err_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_sel_q   <= err_sel_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_sel   = err_sel_q;
    assign err_count = err_count_q;

    demux3_buf_slot #(.W(d_width)) u_slot0 (.clk(clk), .rst_n(rst_n), .wr_en(wr0), .wr_data(in_data),
        .out_valid(out0_valid), .out_ready(out0_ready), .out_data(out0_data));
    demux3_buf_slot #(.W(d_width)) u_slot1 (.clk(clk), .rst_n(rst_n), .wr_en(wr1), .wr_data(in_data),
        .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data));
    demux3_buf_slot #(.W(d_width)) u_slot2 (.clk(clk), .rst_n(rst_n), .wr_en(wr2), .wr_data(in_data),
        .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data));
endmodule
